// File: rtl/kb_cmd_ctrl.sv
// Keyboard command controller: acknowledges PS/2 release codes, drives a field
// cursor with an idle-timeout edit mode, and queues decoded commands for a consumer.
module kb_cmd_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int NFIELDS    = 3,
  parameter int TIMEOUT    = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_code,
  input  logic       key_irq,
  output logic       rd_key_code,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [1:0] cmd_field,
  input  logic       cmd_ready,
  output logic       edit_mode,
  output logic [1:0] field_sel,
  output logic       overflow
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW:0]     FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   IDLE_LAST  = CW'(TIMEOUT - 1);
  localparam logic [1:0]      LAST_FIELD = 2'(NFIELDS - 1);

  typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_t;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DOWN  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_ENTER = 3'd5,
    CMD_ESC   = 3'd6
  } cmd_t;

  typedef struct packed {
    logic [1:0] field;
    cmd_t       code;
  } entry_t;

  state_t        state;
  cmd_t          dec;
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [CW-1:0] idle_cnt;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          do_write;

  always_comb begin
    dec = CMD_NONE;
    case (key_code)
      8'h1D:   dec = CMD_UP;
      8'h1B:   dec = CMD_DOWN;
      8'h1C:   dec = CMD_LEFT;
      8'h23:   dec = CMD_RIGHT;
      8'h5A:   dec = CMD_ENTER;
      8'h76:   dec = CMD_ESC;
      default: dec = CMD_NONE;
    endcase
  end

  // A key is only taken while idle; unknown codes are acknowledged but never queued.
  assign accept    = (state == IDLE) && key_irq;
  assign push      = accept && (dec != CMD_NONE);
  assign full      = (count == FULL_CNT);
  assign cmd_valid = (count != '0);
  assign pop       = cmd_valid && cmd_ready;
  assign do_write  = push && (!full || pop);

  assign cmd_code  = cmd_valid ? mem[rd_ptr].code  : 3'd0;
  assign cmd_field = cmd_valid ? mem[rd_ptr].field : 2'd0;

  // NOTE: queue storage has no reset; valid data is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= '{field: field_sel, code: dec};
  end

  // NOTE: all state uses non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rd_key_code <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      edit_mode   <= 1'b0;
      field_sel   <= 2'd0;
      overflow    <= 1'b0;
      idle_cnt    <= '0;
    end else begin
      rd_key_code <= 1'b0;
      case (state)
        IDLE: if (key_irq) begin
          state       <= ACK;
          rd_key_code <= 1'b1;
        end
        ACK:      state <= WAIT_CLR;
        WAIT_CLR: if (!key_irq) state <= IDLE;
        default:  state <= IDLE;
      endcase

      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (do_write && !pop)      count <= count + 1'b1;
      else if (!do_write && pop) count <= count - 1'b1;
      if (push && !do_write) overflow <= 1'b1;

      // An accepted key outranks a timeout landing on the same edge.
      if (accept) begin
        case (dec)
          CMD_ENTER: begin
            if (edit_mode) edit_mode <= 1'b0;
            else begin
              edit_mode <= 1'b1;
              field_sel <= 2'd0;
            end
          end
          CMD_ESC: begin
            edit_mode <= 1'b0;
            field_sel <= 2'd0;
          end
          CMD_RIGHT: if (edit_mode)
            field_sel <= (field_sel == LAST_FIELD) ? 2'd0 : field_sel + 2'd1;
          CMD_LEFT: if (edit_mode)
            field_sel <= (field_sel == 2'd0) ? LAST_FIELD : field_sel - 2'd1;
          default: ;
        endcase
      end else if (edit_mode && (idle_cnt == IDLE_LAST)) begin
        edit_mode <= 1'b0;
        field_sel <= 2'd0;
      end

      if (accept || !edit_mode) idle_cnt <= '0;
      else                      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: doc/kb_cmd_ctrl.md
KB_CMD_CTRL -- requirements
Module: kb_cmd_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command-queue depth in entries (power of two, >=2).
REQ-002 Parameter NFIELDS, default 3, number of editable fields selectable by the cursor.
REQ-003 Parameter TIMEOUT, default 50_000_000, idle clk cycles after which edit mode exits automatically.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 key_code  input  8  released-key scan code (PS/2 set 2) from the keyboard decoder.
REQ-007 key_irq  input  1  high while key_code holds an unread code.
REQ-008 rd_key_code  output  1  one-cycle acknowledge pulse to the keyboard decoder.
REQ-009 cmd_valid  output  1  head-of-queue entry is valid.
REQ-010 cmd_code  output  3  head-of-queue command: 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 ENTER, 6 ESC.
REQ-011 cmd_field  output  2  field_sel value captured with the head entry.
REQ-012 cmd_ready  input  1  consumer accepts head entry when high with cmd_valid.
REQ-013 edit_mode  output  1  high while field editing is active.
REQ-014 field_sel  output  2  current cursor field, 0..NFIELDS-1.
REQ-015 overflow  output  1  sticky flag: a command was lost to a full queue.

Function
REQ-016 Scan-code decode SHALL be: 1D->UP, 1B->DOWN, 1C->LEFT, 23->RIGHT, 5A->ENTER, 76->ESC; any other code SHALL be acknowledged and discarded with no other effect.
REQ-017 Handshake FSM states SHALL be IDLE, ACK, WAIT_CLR.
REQ-018 IDLE: on key_irq=1 the block SHALL sample key_code, decode, apply cursor/queue effects in that same edge, and go to ACK.
REQ-019 ACK: rd_key_code SHALL be 1 for exactly this one cycle; next state WAIT_CLR.
REQ-020 WAIT_CLR: stay while key_irq=1; go to IDLE when key_irq=0; no new code SHALL be sampled in ACK or WAIT_CLR.
REQ-021 ENTER SHALL toggle edit_mode; entering edit mode SHALL set field_sel to 0.
REQ-022 ESC SHALL clear edit_mode and set field_sel to 0.
REQ-023 In edit mode RIGHT SHALL increment field_sel, wrapping NFIELDS-1->0; LEFT SHALL decrement, wrapping 0->NFIELDS-1.
REQ-024 Outside edit mode LEFT/RIGHT/UP/DOWN SHALL not change field_sel.
REQ-025 Every decoded command (all six codes) SHALL be pushed as {field_sel before update, cmd_code}.
REQ-026 Queue SHALL be FIFO order; cmd_code/cmd_field SHALL show head entry whenever cmd_valid=1, and SHALL be 0 when empty.
REQ-027 Pop SHALL occur on an edge where cmd_valid=1 and cmd_ready=1.
REQ-028 Push when full without simultaneous pop SHALL drop the new command, leave queue unchanged, set overflow=1.
REQ-029 Push and pop on the same edge SHALL both succeed, including when full; occupancy unchanged.
REQ-030 overflow SHALL clear only on reset.
REQ-031 Idle counter SHALL reset to 0 on every accepted key (REQ-018) and whenever edit_mode=0, and otherwise increment while edit_mode=1.
REQ-032 When idle counter reaches TIMEOUT-1 with edit_mode=1, edit_mode SHALL clear and field_sel SHALL go to 0 on the next edge; no command is pushed.
REQ-033 A key accepted on the same edge as timeout SHALL take priority; timeout is ignored that edge.

Reset
REQ-034 On reset: FSM IDLE, rd_key_code=0, queue empty, cmd_valid=0, cmd_code=0, cmd_field=0, edit_mode=0, field_sel=0, overflow=0, idle counter 0.
REQ-035 Reset asserted mid-handshake SHALL abandon it; after release, a still-high key_irq SHALL be treated as a new code.

Verification
REQ-036 key_code=5A, key_irq=1 for 3 cycles -> rd_key_code one pulse 1 cycle after sample, edit_mode=1, field_sel=0, queue head {0,5}.
REQ-037 Edit mode, RIGHT x3 (NFIELDS=3) -> field_sel 1,2,0; LEFT once -> 2; entries carry fields 0,1,2,0.
REQ-038 cmd_ready=0, five valid keys (FIFO_DEPTH=4) -> cmd_valid=1, four entries retained in order, fifth dropped, overflow=1; cmd_ready=1 then drains 4 entries.
REQ-039 Full queue, key arrives same edge as pop -> occupancy stays 4, overflow stays 0, new entry at tail.
REQ-040 TIMEOUT=16, ENTER then no keys -> edit_mode clears exactly 16 cycles after counter starts; key code 0x2A -> acknowledged, no push, no state change.
REQ-041 Reset pulse during ACK with key_irq held high -> all outputs reset values, code re-sampled in first IDLE cycle after release.
